// File: rtl/final_tank_palette_encoder.sv
// Reverse lookup of a 12-bit RGB colour onto the 16-entry tank palette.
// Scans one entry per clock and reports the nearest index by Manhattan distance.
module final_tank_palette_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       busy,
  output logic       done,
  output logic [3:0] index,
  output logic [5:0] distance
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] r_q, g_q, b_q;
  logic [3:0] ptr;
  logic [5:0] best_dist;
  logic [3:0] best_idx;

  logic [11:0] entry;
  logic [5:0]  d;
  logic        hit;
  logic        finish;
  logic [5:0]  upd_dist;
  logic [3:0]  upd_idx;

  function automatic logic [11:0] palette(input logic [3:0] i);
    case (i)
      4'd0:    palette = 12'hD27;
      4'd1:    palette = 12'hEA0;
      4'd2:    palette = 12'h660;
      4'd3:    palette = 12'hFE8;
      4'd4:    palette = 12'hD07;
      4'd5:    palette = 12'hD16;
      4'd6:    palette = 12'hFB0;
      4'd7:    palette = 12'h660;
      4'd8:    palette = 12'hFE8;
      4'd9:    palette = 12'hEC7;
      4'd10:   palette = 12'hE90;
      4'd11:   palette = 12'h560;
      4'd12:   palette = 12'hFA0;
      4'd13:   palette = 12'hFD7;
      4'd14:   palette = 12'h770;
      default: palette = 12'h761;
    endcase
  endfunction

  function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    absdiff = (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    entry    = palette(ptr);
    d        = {2'b00, absdiff(r_q, entry[11:8])}
             + {2'b00, absdiff(g_q, entry[7:4])}
             + {2'b00, absdiff(b_q, entry[3:0])};
    // strict compare keeps the lower index on ties and duplicate colours
    hit      = (d < best_dist);
    upd_dist = hit ? d   : best_dist;
    upd_idx  = hit ? ptr : best_idx;
    finish   = (d == 6'd0) || (ptr == 4'd15);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (finish) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      ptr       <= '0;
      best_dist <= '0;
      best_idx  <= '0;
      index     <= '0;
      distance  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r_q       <= red;
          g_q       <= green;
          b_q       <= blue;
          ptr       <= '0;
          best_dist <= '1;
          best_idx  <= '0;
        end
        SCAN: begin
          best_dist <= upd_dist;
          best_idx  <= upd_idx;
          if (finish) begin
            index    <= upd_idx;
            distance <= upd_dist;
          end else begin
            ptr <= ptr + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_final_tank_palette_encoder.sv
// Directed test of the tank palette encoder: exact hits, full scans, ties,
// ignored restarts, back-to-back queries and asynchronous reset mid-scan.
module tb_final_tank_palette_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic       busy, done;
  logic [3:0] index;
  logic [5:0] distance;

  int checks = 0;
  int errors = 0;

  final_tank_palette_encoder dut (
    .clk(clk), .rst(rst), .start(start),
    .red(red), .green(green), .blue(blue),
    .busy(busy), .done(done), .index(index), .distance(distance)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after an edge; returns after E0 (+1).
  task automatic launch(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic hold);
    red = r; green = g; blue = b; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts edges until done is seen; n = -1 if the bound expires.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || index !== 4'd0 || distance !== 6'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b index=%0d dist=%0d, want 0 0 0 0",
               busy, done, index, distance);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input int exp_n, input logic [3:0] exp_idx);
    int n;
    launch(r, g, b, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL exact_busy_after_e0: busy=%b want 1", busy);
    end
    wait_done(40, n);
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL exact_latency %h%h%h: done at E%0d want E%0d", r, g, b, n, exp_n);
    end
    checks++;
    if (index !== exp_idx || distance !== 6'd0) begin
      errors++;
      $display("FAIL exact_result %h%h%h: index=%0d dist=%0d want %0d 0", r, g, b, index, distance, exp_idx);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || index !== exp_idx) begin
      errors++;
      $display("FAIL exact_after_done: done=%b busy=%b index=%0d want 0 0 %0d", done, busy, index, exp_idx);
    end
  endtask

  task automatic test_full_scan;
    int n;
    launch(4'h0, 4'h0, 4'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || index !== 4'd2 || distance !== 6'd0) begin
      errors++;
      $display("FAIL scan_hold: busy=%b done=%b index=%0d dist=%0d want 1 0 2 0", busy, done, index, distance);
    end
    wait_done(40, n);
    checks++;
    if (n !== 11) begin
      errors++; $display("FAIL scan_latency: done at E%0d want E16", n < 0 ? n : n + 5);
    end
    checks++;
    if (index !== 4'd11 || distance !== 6'd11) begin
      errors++; $display("FAIL scan_result: index=%0d dist=%0d want 11 11", index, distance);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL scan_done_pulse: done=%b busy=%b after E17 want 0 0", done, busy);
    end
  endtask

  task automatic test_tie;
    int n;
    launch(4'hF, 4'hF, 4'hF, 1'b0);
    wait_done(40, n);
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL tie_latency: done at E%0d want E16", n);
    end
    checks++;
    if (index !== 4'd3 || distance !== 6'd8) begin
      errors++; $display("FAIL tie_result: index=%0d dist=%0d want 3 8", index, distance);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    launch(4'h0, 4'h0, 4'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    red = 4'hD; green = 4'h2; blue = 4'h7;
    wait_done(40, n);
    checks++;
    if (n !== 14 || index !== 4'd11 || distance !== 6'd11) begin
      errors++;
      $display("FAIL b2b_first: done at E%0d index=%0d dist=%0d want E16 11 11",
               n < 0 ? n : n + 2, index, distance);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || index !== 4'd11) begin
      errors++; $display("FAIL b2b_second_accept: busy=%b index=%0d want 1 11", busy, index);
    end
    wait_done(40, n);
    checks++;
    if (n !== 1 || index !== 4'd0 || distance !== 6'd0) begin
      errors++;
      $display("FAIL b2b_second: done at +%0d index=%0d dist=%0d want +1 0 0", n, index, distance);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan;
    int n;
    launch(4'hF, 4'hF, 4'hF, 1'b0);
    wait_done(40, n);
    @(posedge clk); #1;
    launch(4'h0, 4'h0, 4'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || index !== 4'd0 || distance !== 6'd0) begin
      errors++;
      $display("FAIL midscan_reset: busy=%b done=%b index=%0d dist=%0d want 0 0 0 0",
               busy, done, index, distance);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_done(20, n);
    checks++;
    if (n !== -1 || busy !== 1'b0) begin
      errors++; $display("FAIL midscan_no_done: done seen at +%0d busy=%b want none 0", n, busy);
    end
    launch(4'h0, 4'h0, 4'h0, 1'b0);
    wait_done(40, n);
    checks++;
    if (n !== 16 || index !== 4'd11 || distance !== 6'd11) begin
      errors++;
      $display("FAIL midscan_fresh: done at E%0d index=%0d dist=%0d want E16 11 11", n, index, distance);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_exact(4'hD, 4'h2, 4'h7, 1, 4'd0);
    test_exact(4'hF, 4'hE, 4'h8, 4, 4'd3);
    test_exact(4'h6, 4'h6, 4'h0, 3, 4'd2);
    test_full_scan;
    test_tie;
    test_back_to_back;
    test_reset_mid_scan;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
